uart_rx_frame_ctrl: RTL and testbench

Receive-side frame controller for the UART receiver. It synchronises the raw serial line and detects the start bit. It times mid-bit sample points and drives shift_strobe into the 9-bit serial-to-parallel shift register (NUM_BITS=DATA_BITS+1, SHIFT_MSB=0, LSB-first data, stop bit lands in MSB). It then consumes that register's parallel output, checks the stop bit and holds the received byte for the host with a ready/read handshake and error flags.

---
 rtl/uart_rx_frame_ctrl.sv | 140 ++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
module uart_rx_frame_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic [DATA_BITS:0]   packet_data,
  input  logic                 data_read,
  output logic                 shift_strobe,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS + 2);

  typedef enum logic [1:0] {
    IDLE,
    START_CHK,
    SAMPLE,
    CHECK
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sync1_q, sync2_q, hist_q;
  logic            start_edge;
  logic            start_ok;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign start_edge = hist_q & ~sync2_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    cnt_d        = cnt_q;
    shift_strobe = 1'b0;
    start_ok     = 1'b0;
    busy         = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = START_CHK;
          timer_d = '0;
          cnt_d   = '0;
        end
      end
      START_CHK: begin
        if (timer_q == TW'(H - 1)) begin
          timer_d = '0;
          if (!sync2_q) begin
            state_d  = SAMPLE;
            start_ok = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      SAMPLE: begin
        if (timer_q == TW'(CLKS_PER_BIT - 1)) begin
          shift_strobe = 1'b1;
          timer_d      = '0;
          cnt_d        = cnt_q + 1'b1;
          if (cnt_q == CW'(DATA_BITS)) begin
            state_d = CHECK;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      CHECK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Host read is applied first so that a same-cycle CHECK load overrides it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data       <= '0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (data_read && data_ready) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
      if (start_ok) begin
        framing_error <= 1'b0;
      end
      if (state_q == CHECK) begin
        if (packet_data[DATA_BITS]) begin
          rx_data    <= packet_data[DATA_BITS-1:0];
          data_ready <= 1'b1;
          if (data_ready && !data_read) begin
            overrun_error <= 1'b1;
          end
        end else begin
          framing_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
module tb_uart_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       serial_in;
  logic [8:0] packet_data;
  logic       data_read;
  logic       shift_strobe;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       overrun_error;
  logic       framing_error;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] d;
    logic       rdy;
    logic       ovr;
    logic       ferr;
  } exp_t;

  exp_t sb[$];
  int   strobe_times[$];
  int   frame_strobes = 0;
  int   last_fall = -1;
  logic busy_prev = 1'b0;

  logic       bs1 = 1'b1;
  logic       bs2 = 1'b1;
  logic [8:0] sr  = '0;

  uart_rx_frame_ctrl #(
    .CLKS_PER_BIT(10),
    .DATA_BITS(8)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .serial_in(serial_in),
    .packet_data(packet_data),
    .data_read(data_read),
    .shift_strobe(shift_strobe),
    .rx_data(rx_data),
    .data_ready(data_ready),
    .overrun_error(overrun_error),
    .framing_error(framing_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // external synchroniser + LSB-first shift register, stop bit lands in [8]
  always @(posedge clk) begin
    bs1 <= serial_in;
    bs2 <= bs1;
    if (shift_strobe) sr <= {bs2, sr[8:1]};
  end
  assign packet_data = sr;

  always @(negedge clk) begin
    if (shift_strobe) begin
      strobe_times.push_back(cyc);
      if (frame_strobes == 0) begin
        checks++;
        if (framing_error !== 1'b0) begin
          errors++;
          $display("FAIL ferr_at_first_strobe got=%b exp=0", framing_error);
        end
      end
      frame_strobes++;
    end
    if (busy_prev && !busy) begin
      last_fall = cyc;
      if (frame_strobes == 9) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow got=frame exp=none");
        end else begin
          exp_t e;
          e = sb.pop_front();
          checks += 3;
          if (rx_data !== e.d) begin
            errors++;
            $display("FAIL sb_rx_data got=%h exp=%h", rx_data, e.d);
          end
          if (data_ready !== e.rdy) begin
            errors++;
            $display("FAIL sb_data_ready got=%b exp=%b", data_ready, e.rdy);
          end
          if (overrun_error !== e.ovr) begin
            errors++;
            $display("FAIL sb_overrun got=%b exp=%b", overrun_error, e.ovr);
          end
          if (framing_error !== e.ferr) begin
            errors++;
            $display("FAIL sb_framing got=%b exp=%b", framing_error, e.ferr);
          end
        end
      end
      frame_strobes = 0;
    end
    if (!n_rst) frame_strobes = 0;
    busy_prev = busy;
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int unsigned stop_len);
    serial_in = 1'b0;
    step(10);
    for (int unsigned i = 0; i < 8; i++) begin
      serial_in = d[i];
      step(10);
    end
    serial_in = stop;
    step(stop_len);
    serial_in = 1'b1;
  endtask

  task automatic host_read();
    data_read = 1'b1;
    step(1);
    data_read = 1'b0;
    checks++;
    if (data_ready !== 1'b0 || overrun_error !== 1'b0) begin
      errors++;
      $display("FAIL read_clear got=%b%b exp=00", data_ready, overrun_error);
    end
  endtask

  task automatic test_reset();
    n_rst     = 1'b0;
    serial_in = 1'b1;
    data_read = 1'b0;
    step(3);
    checks++;
    if ({rx_data, data_ready, overrun_error, framing_error, busy, shift_strobe} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h %b%b%b%b%b exp=00 00000", rx_data, data_ready,
               overrun_error, framing_error, busy, shift_strobe);
    end
    n_rst = 1'b1;
    step(3);
  endtask

  task automatic test_good_frame();
    int t;
    strobe_times.delete();
    t = cyc;
    sb.push_back('{8'hA5, 1'b1, 1'b0, 1'b0});
    send_frame(8'hA5, 1'b1, 10);
    step(3);
    checks++;
    if (strobe_times.size() != 9) begin
      errors++;
      $display("FAIL good_strobe_count got=%0d exp=9", strobe_times.size());
    end else begin
      for (int unsigned k = 0; k < 9; k++) begin
        checks++;
        if (strobe_times[k] != t + 17 + 10 * int'(k)) begin
          errors++;
          $display("FAIL good_strobe_time k=%0d got=%0d exp=%0d", k, strobe_times[k] - t - 2,
                   15 + 10 * int'(k));
        end
      end
    end
    checks++;
    if (last_fall != t + 99) begin
      errors++;
      $display("FAIL good_busy_fall got=E+%0d exp=E+97", last_fall - t - 2);
    end
    host_read();
  endtask

  task automatic test_false_start();
    int n;
    n = strobe_times.size();
    serial_in = 1'b0;
    step(3);
    serial_in = 1'b1;
    step(20);
    checks += 2;
    if (strobe_times.size() != n) begin
      errors++;
      $display("FAIL false_start_strobes got=%0d exp=0", strobe_times.size() - n);
    end
    if ({rx_data, data_ready, overrun_error, framing_error, busy} !== {8'hA5, 4'b0000}) begin
      errors++;
      $display("FAIL false_start_outputs got=%h %b%b%b%b exp=a5 0000", rx_data, data_ready,
               overrun_error, framing_error, busy);
    end
  endtask

  task automatic test_framing_error();
    sb.push_back('{8'hA5, 1'b0, 1'b0, 1'b1});
    send_frame(8'h3C, 1'b0, 10);
    step(5);
    sb.push_back('{8'h11, 1'b1, 1'b0, 1'b0});
    send_frame(8'h11, 1'b1, 10);
    step(5);
    host_read();
  endtask

  task automatic test_overrun();
    sb.push_back('{8'h55, 1'b1, 1'b0, 1'b0});
    send_frame(8'h55, 1'b1, 10);
    step(5);
    sb.push_back('{8'hAA, 1'b1, 1'b1, 1'b0});
    send_frame(8'hAA, 1'b1, 10);
    step(5);
    host_read();
  endtask

  task automatic test_simultaneous();
    sb.push_back('{8'h33, 1'b1, 1'b0, 1'b0});
    send_frame(8'h33, 1'b1, 10);
    step(5);
    sb.push_back('{8'h0F, 1'b1, 1'b0, 1'b0});
    fork
      send_frame(8'h0F, 1'b1, 10);
      begin
        step(98);
        data_read = 1'b1;
        step(1);
        data_read = 1'b0;
      end
    join
    step(5);
    host_read();
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    fork
      send_frame(8'hFF, 1'b1, 10);
      begin
        step(42);
        n_rst = 1'b0;
        #1;
        n = strobe_times.size();
        checks++;
        if ({rx_data, data_ready, overrun_error, framing_error, busy, shift_strobe} !== 13'h0) begin
          errors++;
          $display("FAIL midreset_outputs got=%h %b%b%b%b%b exp=00 00000", rx_data, data_ready,
                   overrun_error, framing_error, busy, shift_strobe);
        end
        step(5);
        n_rst = 1'b1;
      end
    join
    step(5);
    checks++;
    if (strobe_times.size() != n) begin
      errors++;
      $display("FAIL midreset_strobes got=%0d exp=0", strobe_times.size() - n);
    end
  endtask

  task automatic test_back_to_back();
    sb.push_back('{8'h81, 1'b1, 1'b0, 1'b0});
    send_frame(8'h81, 1'b1, 7);
    sb.push_back('{8'h7E, 1'b1, 1'b1, 1'b0});
    send_frame(8'h7E, 1'b1, 10);
    step(5);
    host_read();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_false_start();
    test_framing_error();
    test_overrun();
    test_simultaneous();
    test_reset_mid_frame();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
